// File: rtl/password_checker.sv
// password_checker: one-spot code lock that grants on a matching guess and
// locks out for LOCK_CYCLES clocks after MAX_TRIES wrong guesses.
module password_checker #(
   parameter int MAX_TRIES   = 3,
   parameter int LOCK_CYCLES = 50_000_000
) (
   input  logic       CLOCK_50,
   input  logic       resetn,
   input  logic       issue,
   input  logic [9:0] PASSWORD,
   input  logic       enter,
   input  logic [9:0] GUESS,
   output logic       occupied,
   output logic       grant,
   output logic       deny,
   output logic       locked,
   output logic [1:0] tries_left
);
   typedef enum logic [1:0] {FREE, ARMED, LOCKED} state_t;
   localparam logic [1:0]  MAX  = 2'(MAX_TRIES);
   localparam logic [25:0] LOAD = 26'(LOCK_CYCLES - 1);
   state_t      state, state_d;
   logic [9:0]  code, code_d;
   logic [1:0]  tries_d;
   logic [25:0] cnt, cnt_d;
   logic        grant_d, deny_d;
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         state      <= FREE;
         code       <= '0;
         tries_left <= '0;
         cnt        <= '0;
         grant      <= 1'b0;
         deny       <= 1'b0;
         occupied   <= 1'b0;
         locked     <= 1'b0;
      end else begin
         state      <= state_d;
         code       <= code_d;
         tries_left <= tries_d;
         cnt        <= cnt_d;
         grant      <= grant_d;
         deny       <= deny_d;
         occupied   <= state_d != FREE;
         locked     <= state_d == LOCKED;
      end
   end
   always_comb begin
      state_d = state;
      code_d  = code;
      tries_d = tries_left;
      cnt_d   = cnt;
      grant_d = 1'b0;
      deny_d  = 1'b0;
      case (state)
         FREE: if (issue) begin
            code_d  = PASSWORD;
            tries_d = MAX;
            state_d = ARMED;
         end
         ARMED: if (enter) begin
            if (GUESS == code) begin
               grant_d = 1'b1;
               code_d  = '0;
               tries_d = '0;
               state_d = FREE;
            end else begin
               deny_d  = 1'b1;
               tries_d = tries_left - 2'd1;
               // last try used up: counter is loaded only here, so it never wraps
               if (tries_left <= 2'd1) begin
                  tries_d = '0;
                  cnt_d   = LOAD;
                  state_d = LOCKED;
               end
            end
         end
         LOCKED: if (cnt == '0) begin
            tries_d = MAX;
            state_d = ARMED;
         end else begin
            cnt_d = cnt - 26'd1;
         end
         default: state_d = FREE;
      endcase
   end
endmodule

// File: tb/tb_password_checker.sv
// tb_password_checker: directed stimulus with a behavioural model checked every
// cycle, plus literal spot checks on key outputs.
module tb_password_checker;
   localparam int MT = 3;
   localparam int LC = 8;
   logic       clk = 1'b0;
   logic       resetn = 1'b1;
   logic       issue = 1'b0, enter = 1'b0;
   logic [9:0] pw = '0, guess = '0;
   logic       occupied, grant, deny, locked;
   logic [1:0] tries_left;
   int         n = 0, errs = 0;
   bit         go = 1'b0;
   bit         m_occ = 0, m_grant = 0, m_deny = 0;
   logic [9:0] m_code = '0;
   int         m_tries = 0, lock_rem = 0;

   password_checker #(.MAX_TRIES(MT), .LOCK_CYCLES(LC)) dut (
      .CLOCK_50(clk), .resetn(resetn), .issue(issue), .PASSWORD(pw),
      .enter(enter), .GUESS(guess), .occupied(occupied), .grant(grant),
      .deny(deny), .locked(locked), .tries_left(tries_left)
   );

   always #5 clk = ~clk;

   // behavioural model: lock_rem is the number of locked cycles still to show
   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         m_occ = 0; m_grant = 0; m_deny = 0; m_code = '0; m_tries = 0; lock_rem = 0;
      end else begin
         m_grant = 0;
         m_deny  = 0;
         if (lock_rem > 0) begin
            lock_rem = lock_rem - 1;
            if (lock_rem == 0) m_tries = MT;
         end else if (m_occ) begin
            if (enter) begin
               if (guess == m_code) begin
                  m_grant = 1; m_occ = 0; m_code = '0; m_tries = 0;
               end else begin
                  m_deny  = 1;
                  m_tries = m_tries - 1;
                  if (m_tries == 0) lock_rem = LC;
               end
            end
         end else if (issue) begin
            m_code = pw; m_tries = MT; m_occ = 1;
         end
      end
   end

   always @(negedge clk) if (go) begin
      logic [5:0] exp_v, act_v;
      exp_v = {m_occ, m_grant, m_deny, lock_rem > 0, 2'(m_tries)};
      act_v = {occupied, grant, deny, locked, tries_left};
      n++;
      if (act_v !== exp_v) begin
         errs++;
         $display("FAIL model t=%0t: got %b expected %b", $time, act_v, exp_v);
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      n++;
      if (act != exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic step(input bit i, input logic [9:0] p, input bit e, input logic [9:0] g);
      issue = i; pw = p; enter = e; guess = g;
      @(posedge clk); #1;
      issue = 0; enter = 0;
   endtask

   task automatic idle();
      step(0, '0, 0, '0);
   endtask

   initial begin
      int cnt;
      #1 resetn = 1'b0;
      repeat (2) @(posedge clk);
      go = 1'b1;
      #1;
      chk("reset_outputs", {occupied, grant, deny, locked, tries_left}, 0);
      resetn = 1'b1;
      idle();
      // basic grant
      step(1, 10'h2A5, 0, '0);
      chk("armed_occupied", occupied, 1);
      chk("armed_tries", tries_left, 3);
      step(0, '0, 1, 10'h2A5);
      chk("grant_2a5", grant, 1);
      chk("grant_occ0", occupied, 0);
      idle();
      chk("grant_one_cycle", grant, 0);
      // three wrong guesses, lockout with an enter attempt inside it
      step(1, 10'h2A5, 0, '0);
      step(0, '0, 1, 10'h000);
      chk("deny1", deny, 1);
      chk("tries2", tries_left, 2);
      step(0, '0, 1, 10'h000);
      chk("tries1", tries_left, 1);
      step(0, '0, 1, 10'h000);
      chk("deny3", deny, 1);
      chk("tries0", tries_left, 0);
      chk("locked_now", locked, 1);
      cnt = 0;
      for (int k = 0; k < 100 && locked; k++) begin
         cnt++;
         if (k == 2) step(0, '0, 1, 10'h2A5);
         else idle();
      end
      chk("lock_len", cnt, 8);
      chk("tries_restored", tries_left, 3);
      step(0, '0, 1, 10'h2A5);
      chk("grant_after_lock", grant, 1);
      // simultaneous issue/enter in FREE, re-issue ignored in ARMED
      step(1, 10'h3FF, 1, 10'h3FF);
      chk("sim_no_grant", grant, 0);
      chk("sim_occupied", occupied, 1);
      step(1, 10'h001, 0, '0);
      step(0, '0, 1, 10'h3FF);
      chk("grant_3ff", grant, 1);
      // zero code is valid
      step(1, 10'h000, 0, '0);
      step(0, '0, 1, 10'h000);
      chk("grant_zero", grant, 1);
      // reset in the middle of a lockout
      step(1, 10'h155, 0, '0);
      repeat (3) step(0, '0, 1, 10'h0AA);
      chk("locked_again", locked, 1);
      repeat (3) idle();
      #2 resetn = 1'b0;
      #1;
      chk("async_reset", {occupied, grant, deny, locked, tries_left}, 0);
      repeat (3) @(posedge clk);
      #1 resetn = 1'b1;
      step(0, '0, 1, 10'h155);
      chk("free_enter_ign", {occupied, grant, deny}, 0);
      step(1, 10'h155, 0, '0);
      chk("rearm_occ", occupied, 1);
      chk("rearm_tries", tries_left, 3);
      step(0, '0, 1, 10'h155);
      chk("grant_155", grant, 1);
      idle();
      $display("== %0d vectors applied, %0d miscompares ==", n, errs);
      $finish;
   end
endmodule
